// File: rtl/sa_pkg.sv
// Shared parameters, FSM state types and ROM contents for the 2x2 systolic tile.
package sa_pkg;

  localparam int ADDR_W        = 6;
  localparam int DATA_W        = 8;
  localparam int WEIGHT_BASE   = 16;
  localparam int IMG_W         = 4;
  localparam int ROM_IDENT_END = 16;

  typedef enum logic [1:0] {
    WL_IDLE = 2'd0,
    WL_LOAD = 2'd1,
    WL_DONE = 2'd2
  } wl_state_e;

  typedef enum logic [2:0] {
    FL_IDLE  = 3'd0,
    FL_FETCH = 3'd1,
    FL_DRAIN = 3'd2,
    FL_WRITE = 3'd3,
    FL_DONE  = 3'd4
  } fl_state_e;

  localparam logic [2:0] SEL_C11 = 3'd0;
  localparam logic [2:0] SEL_C12 = 3'd1;
  localparam logic [2:0] SEL_C21 = 3'd2;
  localparam logic [2:0] SEL_C22 = 3'd3;

  // Low region holds a+1, the four weights sit at WEIGHT_BASE, the rest is zero.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    if (a < ADDR_W'(ROM_IDENT_END)) begin
      v = DATA_W'(a) + DATA_W'(1);
    end else if (a < ADDR_W'(WEIGHT_BASE + 4)) begin
      v = DATA_W'(a - ADDR_W'(WEIGHT_BASE)) + DATA_W'(1);
    end else begin
      v = '0;
    end
    return v;
  endfunction

endpackage

// File: rtl/sa_rom.sv
// 64x8 fixed-content ROM with a registered (one-cycle) read port.
module sa_rom
  import sa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_data <= '0;
    end else begin
      o_data <= rom_word(i_addr);
    end
  end

endmodule

// File: rtl/top_systolic_mode.sv
// 2x2 weight-stationary systolic tile: weight preloader, feature-window loader,
// inline PE products summed into one of four result registers.
module top_systolic_mode
  import sa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              Weight_Preloader_en,
  input  logic              Feature_Loader_en,
  input  logic [ADDR_W-1:0] feature_baseaddr,
  input  logic              systolic_mode,
  input  logic [2:0]        c_reg_sel,
  output logic              is_FL_done_o,
  output logic              is_WL_done_o,
  output logic [DATA_W-1:0] c11,
  output logic [DATA_W-1:0] c12,
  output logic [DATA_W-1:0] c21,
  output logic [DATA_W-1:0] c22
);

  wl_state_e         r_wl_state, w_wl_next;
  fl_state_e         r_fl_state, w_fl_next;
  logic [2:0]        r_wl_cnt;
  logic [1:0]        r_fl_cnt;
  logic              r_wl_vld, r_fl_vld;
  logic [1:0]        r_wl_idx, r_fl_idx;
  logic [DATA_W-1:0] r_w [4];
  logic [DATA_W-1:0] r_p [4];
  logic [ADDR_W-1:0] r_base;
  logic [2:0]        r_sel;
  logic              r_wl_done, r_fl_done;
  logic [DATA_W-1:0] r_c11, r_c12, r_c21, r_c22;

  logic              w_wl_go, w_fl_go, w_wl_rd, w_fl_write;
  logic [ADDR_W-1:0] w_wl_addr, w_fl_addr, w_rom_addr;
  logic [DATA_W-1:0] w_rom_q, w_sum;

  assign w_wl_go    = Weight_Preloader_en & ~systolic_mode;
  assign w_fl_go    = Feature_Loader_en & systolic_mode;
  assign w_wl_rd    = (r_wl_state == WL_LOAD) && (r_wl_cnt < 3'd4);
  assign w_fl_write = (r_fl_state == FL_WRITE) && w_fl_go;
  assign w_wl_addr  = ADDR_W'(WEIGHT_BASE) + {{(ADDR_W-2){1'b0}}, r_wl_cnt[1:0]};
  assign w_rom_addr = (r_wl_state == WL_LOAD) ? w_wl_addr : w_fl_addr;
  assign w_sum      = r_p[0] + r_p[1] + r_p[2] + r_p[3];

  sa_rom u_rom (
    .clk    (clk),
    .rst    (rst),
    .i_addr (w_rom_addr),
    .o_data (w_rom_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wl_state <= WL_IDLE;
      r_fl_state <= FL_IDLE;
      r_wl_cnt   <= 3'd0;
      r_fl_cnt   <= 2'd0;
    end else begin
      r_wl_state <= w_wl_next;
      r_fl_state <= w_fl_next;
      r_wl_cnt   <= (w_wl_next == r_wl_state) ? r_wl_cnt + 3'd1 : 3'd0;
      r_fl_cnt   <= (w_fl_next == r_fl_state) ? r_fl_cnt + 2'd1 : 2'd0;
    end
  end

  // LOAD runs one extra cycle (cnt 4) so the last ROM word lands before DONE.
  always_comb begin
    w_wl_next = r_wl_state;
    case (r_wl_state)
      WL_IDLE: if (w_wl_go) w_wl_next = WL_LOAD; else w_wl_next = WL_IDLE;
      WL_LOAD: begin
        if (!w_wl_go)                w_wl_next = WL_IDLE;
        else if (r_wl_cnt == 3'd4)   w_wl_next = WL_DONE;
        else                         w_wl_next = WL_LOAD;
      end
      WL_DONE: if (w_wl_go) w_wl_next = WL_DONE; else w_wl_next = WL_IDLE;
      default: w_wl_next = WL_IDLE;
    endcase
  end

  always_comb begin
    w_fl_next = r_fl_state;
    case (r_fl_state)
      FL_IDLE: if (w_fl_go) w_fl_next = FL_FETCH; else w_fl_next = FL_IDLE;
      FL_FETCH: begin
        if (!w_fl_go)               w_fl_next = FL_IDLE;
        else if (r_fl_cnt == 2'd3)  w_fl_next = FL_DRAIN;
        else                        w_fl_next = FL_FETCH;
      end
      FL_DRAIN: begin
        if (!w_fl_go)               w_fl_next = FL_IDLE;
        else if (r_fl_cnt == 2'd1)  w_fl_next = FL_WRITE;
        else                        w_fl_next = FL_DRAIN;
      end
      FL_WRITE: if (w_fl_go) w_fl_next = FL_DONE; else w_fl_next = FL_IDLE;
      FL_DONE:  w_fl_next = FL_IDLE;
      default:  w_fl_next = FL_IDLE;
    endcase
  end

  always_comb begin
    w_fl_addr = r_base;
    case (r_fl_cnt)
      2'd0:    w_fl_addr = r_base - ADDR_W'(IMG_W + 1);
      2'd1:    w_fl_addr = r_base - ADDR_W'(IMG_W);
      2'd2:    w_fl_addr = r_base - ADDR_W'(1);
      default: w_fl_addr = r_base;
    endcase
  end

  // ROM data trails the address by one cycle, so index/valid are delayed alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wl_vld <= 1'b0;
      r_wl_idx <= 2'd0;
      r_fl_vld <= 1'b0;
      r_fl_idx <= 2'd0;
      r_base   <= '0;
      r_sel    <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        r_w[i] <= '0;
        r_p[i] <= '0;
      end
    end else begin
      r_wl_vld <= w_wl_rd;
      r_wl_idx <= r_wl_cnt[1:0];
      r_fl_vld <= (r_fl_state == FL_FETCH);
      r_fl_idx <= r_fl_cnt;
      if (r_wl_vld) r_w[r_wl_idx] <= w_rom_q;
      if (r_fl_vld) r_p[r_fl_idx] <= w_rom_q * r_w[r_fl_idx];
      if ((r_fl_state == FL_IDLE) && w_fl_go) begin
        r_base <= feature_baseaddr;
        r_sel  <= c_reg_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wl_done <= 1'b0;
      r_fl_done <= 1'b0;
      r_c11     <= '0;
      r_c12     <= '0;
      r_c21     <= '0;
      r_c22     <= '0;
    end else begin
      r_wl_done <= (w_wl_next == WL_DONE);
      r_fl_done <= w_fl_write;
      if (w_fl_write) begin
        case (r_sel)
          SEL_C11: r_c11 <= w_sum;
          SEL_C12: r_c12 <= w_sum;
          SEL_C21: r_c21 <= w_sum;
          SEL_C22: r_c22 <= w_sum;
          default: ;
        endcase
      end
    end
  end

  assign is_WL_done_o = r_wl_done;
  assign is_FL_done_o = r_fl_done;
  assign c11 = r_c11;
  assign c12 = r_c12;
  assign c21 = r_c21;
  assign c22 = r_c22;

endmodule

// File: tb/tb_top_systolic_mode.sv
// Randomized self-checking bench for top_systolic_mode against a dot-product model.
module tb_top_systolic_mode;

  logic       clk = 1'b0;
  logic       rst;
  logic       Weight_Preloader_en, Feature_Loader_en, systolic_mode;
  logic [5:0] feature_baseaddr;
  logic [2:0] c_reg_sel;
  logic       is_FL_done_o, is_WL_done_o;
  logic [7:0] c11, c12, c21, c22;

  int n_cmp = 0;
  int n_err = 0;
  int m_w [4];
  logic [7:0] m_c [4];

  top_systolic_mode dut (
    .clk                 (clk),
    .rst                 (rst),
    .Weight_Preloader_en (Weight_Preloader_en),
    .Feature_Loader_en   (Feature_Loader_en),
    .feature_baseaddr    (feature_baseaddr),
    .systolic_mode       (systolic_mode),
    .c_reg_sel           (c_reg_sel),
    .is_FL_done_o        (is_FL_done_o),
    .is_WL_done_o        (is_WL_done_o),
    .c11                 (c11),
    .c12                 (c12),
    .c21                 (c21),
    .c22                 (c22)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rom_m(input logic [5:0] a);
    if (a < 16) return int'(a) + 1;
    else if (a < 20) return int'(a) - 15;
    else return 0;
  endfunction

  function automatic logic [7:0] model_dot(input logic [5:0] b);
    int s;
    s = rom_m(b - 6'd5) * m_w[0] + rom_m(b - 6'd4) * m_w[1]
      + rom_m(b - 6'd1) * m_w[2] + rom_m(b) * m_w[3];
    return 8'(s % 256);
  endfunction

  task automatic check_c(input string tag);
    check_val({tag, "_c11"}, c11, m_c[0]);
    check_val({tag, "_c12"}, c12, m_c[1]);
    check_val({tag, "_c21"}, c21, m_c[2]);
    check_val({tag, "_c22"}, c22, m_c[3]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_w[i] = 0;
      m_c[i] = 8'd0;
    end
  endtask

  task automatic run_preload();
    int k;
    Feature_Loader_en   = 1'b0;
    systolic_mode       = 1'b0;
    Weight_Preloader_en = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (is_WL_done_o) begin
        k = i;
        break;
      end
    end
    check_val("wl_done_rise", 32'(k != 0), 32'd1);
    for (int i = 0; i < 4; i++) m_w[i] = rom_m(6'(16 + i));
    repeat (3) tick();
    check_val("wl_done_hold", 32'(is_WL_done_o), 32'd1);
    Weight_Preloader_en = 1'b0;
    tick();
    check_val("wl_done_fall", 32'(is_WL_done_o), 32'd0);
    systolic_mode = 1'b1;
  endtask

  task automatic run_window(input logic [5:0] base, input logic [2:0] sel);
    int k;
    Weight_Preloader_en = 1'b0;
    systolic_mode       = 1'b1;
    Feature_Loader_en   = 1'b1;
    feature_baseaddr    = base;
    c_reg_sel           = sel;
    tick();
    feature_baseaddr = 6'($urandom);
    c_reg_sel        = 3'($urandom);
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (is_FL_done_o) begin
        k = i;
        break;
      end
    end
    check_val("fl_latency", 32'(k), 32'd7);
    if (sel < 3'd4) m_c[sel[1:0]] = model_dot(base);
    check_c("fl_result");
    tick();
    check_val("fl_pulse_width", 32'(is_FL_done_o), 32'd0);
  endtask

  task automatic run_abort(input logic [5:0] base, input logic [2:0] sel,
                           input bit use_mode, input int m);
    bit saw;
    Weight_Preloader_en = 1'b0;
    systolic_mode       = 1'b1;
    Feature_Loader_en   = 1'b1;
    feature_baseaddr    = base;
    c_reg_sel           = sel;
    tick();
    repeat (m) tick();
    if (use_mode) systolic_mode = 1'b0;
    else Feature_Loader_en = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (is_FL_done_o) saw = 1'b1;
    end
    check_val("abort_no_done", 32'(saw), 32'd0);
    check_c("abort_hold");
    Feature_Loader_en = 1'b0;
    systolic_mode     = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    Weight_Preloader_en = 1'b0;
    Feature_Loader_en   = 1'b0;
    systolic_mode       = 1'b0;
    feature_baseaddr    = 6'd0;
    c_reg_sel           = 3'd0;
    model_reset();

    repeat (5) tick();
    check_c("reset");
    check_val("reset_fl_done", 32'(is_FL_done_o), 32'd0);
    check_val("reset_wl_done", 32'(is_WL_done_o), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check_c("idle");
    check_val("idle_fl_done", 32'(is_FL_done_o), 32'd0);
    check_val("idle_wl_done", 32'(is_WL_done_o), 32'd0);

    run_window(6'd9, 3'd0);
    Feature_Loader_en = 1'b0;
    tick();

    run_preload();
    run_window(6'd9, 3'd0);
    run_window(6'd10, 3'd1);
    run_window(6'd13, 3'd2);
    run_window(6'd14, 3'd3);
    run_window(6'd9, 3'd5);
    Feature_Loader_en = 1'b0;
    tick();
    run_abort(6'd9, 3'd0, 1'b0, 1);
    run_abort(6'd10, 3'd1, 1'b0, 6);
    run_abort(6'd13, 3'd2, 1'b1, 3);
    run_window(6'd2, 3'd0);
    run_window(6'd0, 3'd1);
    run_window(6'd63, 3'd2);
    Feature_Loader_en = 1'b0;
    tick();

    for (int it = 0; it < 30; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op == 0) begin
        Feature_Loader_en = 1'b0;
        tick();
        run_preload();
      end else if (op <= 2) begin
        Feature_Loader_en = 1'b0;
        tick();
        run_abort(6'($urandom), 3'($urandom), bit'(op == 2), int'($urandom_range(0, 6)));
      end else begin
        run_window(6'($urandom), 3'($urandom));
      end
    end
    Feature_Loader_en = 1'b0;
    tick();

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    tick();
    check_c("rereset");
    run_window(6'($urandom), 3'($urandom_range(0, 3)));
    Feature_Loader_en = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
